// File: rtl/fifo_wr_arbiter.sv
// Write-side arbiter for the 8x16 FIFO: two valid/ready producers share the
// write port with round-robin ownership limited to BURST words per period.
module fifo_wr_arbiter #(
  parameter int BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [15:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_data,
  output logic        req1_ready,
  input  logic        f_full,
  output logic        fifo_wr_en,
  output logic [15:0] fifo_wr_data,
  output logic [1:0]  grant,
  output logic [15:0] wcount0,
  output logic [15:0] wcount1
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [3:0] BCNT_LAST = 4'(BURST - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] bcnt;
  logic       last;
  logic       release_own;

  // Only the owner may be ready, and never while the FIFO is full or in reset.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!rst) begin
      if (state == OWN0) req0_ready = req0_valid & ~f_full;
      if (state == OWN1) req1_ready = req1_valid & ~f_full;
    end
  end

  assign fifo_wr_en = req0_ready | req1_ready;

  always_comb begin
    fifo_wr_data = 16'h0000;
    if (req0_ready)      fifo_wr_data = req0_data;
    else if (req1_ready) fifo_wr_data = req1_data;
  end

  assign grant = {state == OWN1, state == OWN0};

  // A competitor always takes over on release; a lone owner that still has
  // data simply re-acquires, so burst-limit releases cost no idle cycle.
  always_comb begin
    state_next  = state;
    release_own = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid && req1_valid) state_next = last ? OWN0 : OWN1;
        else if (req0_valid)          state_next = OWN0;
        else if (req1_valid)          state_next = OWN1;
      end
      OWN0: begin
        release_own = (req0_ready && bcnt == BCNT_LAST) || !req0_valid;
        if (release_own) begin
          if (req1_valid)      state_next = OWN1;
          else if (req0_valid) state_next = OWN0;
          else                 state_next = IDLE;
        end
      end
      OWN1: begin
        release_own = (req1_ready && bcnt == BCNT_LAST) || !req1_valid;
        if (release_own) begin
          if (req0_valid)      state_next = OWN0;
          else if (req1_valid) state_next = OWN1;
          else                 state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bcnt    <= 4'd0;
      last    <= 1'b1;
      wcount0 <= 16'h0000;
      wcount1 <= 16'h0000;
    end else begin
      state <= state_next;
      if (release_own) begin
        bcnt <= 4'd0;
        last <= (state == OWN1);
      end else if (fifo_wr_en) begin
        bcnt <= bcnt + 4'd1;
      end
      if (req0_ready) wcount0 <= wcount0 + 16'd1;
      if (req1_ready) wcount1 <= wcount1 + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter with BURST=4.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid;
  logic [15:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [15:0] req1_data;
  logic        req1_ready;
  logic        f_full;
  logic        fifo_wr_en;
  logic [15:0] fifo_wr_data;
  logic [1:0]  grant;
  logic [15:0] wcount0;
  logic [15:0] wcount1;

  int checks   = 0;
  int failures = 0;

  fifo_wr_arbiter #(.BURST(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_data    (req0_data),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_data    (req1_data),
    .req1_ready   (req1_ready),
    .f_full       (f_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .grant        (grant),
    .wcount0      (wcount0),
    .wcount1      (wcount1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic applyStimulus(input logic r, input logic v0, input logic [15:0] d0,
                               input logic v1, input logic [15:0] d1, input logic full);
    @(negedge clk);
    rst        = r;
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
    f_full     = full;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic checkCycle(input string tag, input logic [1:0] g, input logic en,
                            input logic [15:0] d, input logic r0, input logic r1);
    checkOutput({tag, ".grant"}, 32'(grant), 32'(g));
    checkOutput({tag, ".wr_en"}, 32'(fifo_wr_en), 32'(en));
    checkOutput({tag, ".wr_data"}, 32'(fifo_wr_data), 32'(d));
    checkOutput({tag, ".ready0"}, 32'(req0_ready), 32'(r0));
    checkOutput({tag, ".ready1"}, 32'(req1_ready), 32'(r1));
  endtask

  initial begin
    int i0;
    int i1;
    rst = 1'b1; req0_valid = 1'b0; req0_data = 16'h0;
    req1_valid = 1'b0; req1_data = 16'h0; f_full = 1'b0;

    // Reset, then a single producer streaming ten words
    applyStimulus(1, 0, 16'h0, 0, 16'h0, 0);
    checkOutput("rst1.wr_en", 32'(fifo_wr_en), 32'd0);
    applyStimulus(1, 1, 16'h1000, 0, 16'h0, 0);
    checkCycle("rst2", 2'b00, 0, 16'h0, 0, 0);
    checkOutput("rst2.wcount0", 32'(wcount0), 32'd0);
    checkOutput("rst2.wcount1", 32'(wcount1), 32'd0);
    applyStimulus(0, 1, 16'h1000, 0, 16'h0, 0);
    checkCycle("t1_idle", 2'b00, 0, 16'h0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(0, 1, 16'h1000 + 16'(k), 0, 16'h0, 0);
      checkCycle("t1_xfer", 2'b01, 1, 16'h1000 + 16'(k), 1, 0);
    end
    applyStimulus(0, 0, 16'h0, 0, 16'h0, 0);
    checkCycle("t1_drop", 2'b01, 0, 16'h0, 0, 0);
    checkOutput("t1.wcount0", 32'(wcount0), 32'd10);

    // Contention: 4 from producer 0, 4 from producer 1, 4 from producer 0
    applyStimulus(0, 1, 16'h2000, 0, 16'h0, 0);
    checkCycle("t2_idle", 2'b00, 0, 16'h0, 0, 0);
    i0 = 0;
    i1 = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 1, 16'h2000 + 16'(i0), 1, 16'h3000 + 16'(i1), 0);
      if (i < 4 || i >= 8) begin
        checkCycle("t2_own0", 2'b01, 1, 16'h2000 + 16'(i0), 1, 0);
        i0++;
      end else begin
        checkCycle("t2_own1", 2'b10, 1, 16'h3000 + 16'(i1), 0, 1);
        i1++;
      end
    end
    applyStimulus(0, 0, 16'h0, 0, 16'h0, 0);
    checkCycle("t2_drop", 2'b10, 0, 16'h0, 0, 0);
    checkOutput("t2.wcount0", 32'(wcount0), 32'd18);
    checkOutput("t2.wcount1", 32'(wcount1), 32'd4);

    // Full stall after two words; burst count must be preserved
    applyStimulus(0, 1, 16'h4000, 0, 16'h0, 0);
    checkCycle("t3_idle", 2'b00, 0, 16'h0, 0, 0);
    applyStimulus(0, 1, 16'h4000, 0, 16'h0, 0);
    checkCycle("t3_w0", 2'b01, 1, 16'h4000, 1, 0);
    applyStimulus(0, 1, 16'h4001, 0, 16'h0, 0);
    checkCycle("t3_w1", 2'b01, 1, 16'h4001, 1, 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1, 16'h4002, 1, 16'h5000, 1);
      checkCycle("t3_stall", 2'b01, 0, 16'h0, 0, 0);
    end
    applyStimulus(0, 1, 16'h4002, 1, 16'h5000, 0);
    checkCycle("t3_w2", 2'b01, 1, 16'h4002, 1, 0);
    applyStimulus(0, 1, 16'h4003, 1, 16'h5000, 0);
    checkCycle("t3_w3", 2'b01, 1, 16'h4003, 1, 0);

    // Producer 1 owns, moves one word, then drops valid
    applyStimulus(0, 1, 16'h4004, 1, 16'h5000, 0);
    checkCycle("t4_own1", 2'b10, 1, 16'h5000, 0, 1);
    applyStimulus(0, 1, 16'h4004, 0, 16'h0, 0);
    checkCycle("t4_drop", 2'b10, 0, 16'h0, 0, 0);
    applyStimulus(0, 1, 16'h4004, 0, 16'h0, 0);
    checkCycle("t4_own0", 2'b01, 1, 16'h4004, 1, 0);

    // Reset during OWN1 with two words already moved
    applyStimulus(0, 0, 16'h0, 1, 16'h5001, 0);
    checkCycle("t5_hand", 2'b01, 0, 16'h0, 0, 0);
    applyStimulus(0, 1, 16'h4005, 1, 16'h5001, 0);
    checkCycle("t5_w0", 2'b10, 1, 16'h5001, 0, 1);
    applyStimulus(0, 1, 16'h4005, 1, 16'h5002, 0);
    checkCycle("t5_w1", 2'b10, 1, 16'h5002, 0, 1);
    applyStimulus(1, 1, 16'h4005, 1, 16'h5003, 0);
    checkCycle("t5_rst", 2'b10, 0, 16'h0, 0, 0);
    checkOutput("t5_rst.wcount0", 32'(wcount0), 32'd23);
    checkOutput("t5_rst.wcount1", 32'(wcount1), 32'd7);
    applyStimulus(0, 1, 16'h4005, 1, 16'h5003, 0);
    checkCycle("t5_idle", 2'b00, 0, 16'h0, 0, 0);
    checkOutput("t5.wcount0", 32'(wcount0), 32'd0);
    checkOutput("t5.wcount1", 32'(wcount1), 32'd0);
    applyStimulus(0, 1, 16'h4005, 1, 16'h5003, 0);
    checkCycle("t5_tie", 2'b01, 1, 16'h4005, 1, 0);

    // Counter wrap after 65536+3 transfers from producer 0
    applyStimulus(1, 0, 16'h0, 0, 16'h0, 0);
    applyStimulus(0, 1, 16'h0, 0, 16'h0, 0);
    checkCycle("t6_idle", 2'b00, 0, 16'h0, 0, 0);
    for (int i = 0; i < 65539; i++) begin
      applyStimulus(0, 1, 16'(i), 0, 16'h0, 0);
      if (i == 65535) checkOutput("t6.wcount0_max", 32'(wcount0), 32'h0000FFFF);
      if (i == 65536) checkOutput("t6.wcount0_wrap", 32'(wcount0), 32'h0);
    end
    applyStimulus(0, 0, 16'h0, 0, 16'h0, 0);
    checkOutput("t6.wcount0", 32'(wcount0), 32'd3);
    checkOutput("t6.wcount1", 32'(wcount1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Two-requester write-side controller for the 8x16 FIFO. It shares the FIFO write port between producer 0 and producer 1 using round-robin, bounded-burst ownership with valid/ready handshakes. It drives the FIFO `wr_en`/`wr_data` directly and never asserts `wr_en` while `f_full` is high, so the FIFO's `f_overrun` stays low by construction. It sits between the producers and the FIFO instance in the top level.

## Interface
- `BURST`, default 4: maximum words per ownership period; legal range 1..15.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  producer 0 has a word.
- `req0_data`  in  16  producer 0 word.
- `req0_ready`  out  1  word accepted this cycle.
- `req1_valid`, `req1_data`, `req1_ready`: same as producer 0, for producer 1.
- `f_full`  in  1  FIFO full flag.
- `fifo_wr_en`  out  1  FIFO write enable.
- `fifo_wr_data`  out  16  FIFO write data.
- `grant`  out  2  one-hot current owner; `2'b00` when idle.
- `wcount0`  out  16  words accepted from producer 0; wraps modulo 2^16.
- `wcount1`  out  16  words accepted from producer 1; wraps modulo 2^16.

## Operation
- States: IDLE, OWN0, OWN1. Registers:
  - `state`
  - `bcnt[3:0]`, the words moved in the current ownership period
  - `last`, the most recently served requester
  - `wcount0`, `wcount1`
- Reset (`rst`=1 at a clock edge): state=IDLE, bcnt=0, last=1 (producer 0 wins first tie), wcount0=wcount1=0.
- While `rst`=1, `req0_ready`, `req1_ready` and `fifo_wr_en` are forced to 0 combinationally.
- A reset mid-burst abandons the burst. No word is transferred in the reset cycle.
- IDLE behaviour:
  - No transfers; all readies are 0.
  - Only req0_valid: next state is OWN0.
  - Only req1_valid: next state is OWN1.
  - Both valid: next state is OWN(1-last).
  - Neither valid: stay in IDLE.
- OWNx combinational outputs:
  - `reqx_ready = reqx_valid & ~f_full`.
  - The other producer's ready is 0.
  - `fifo_wr_en = reqx_ready`.
  - `fifo_wr_data = reqx_data`.
- `grant` is decoded from the state: OWN0 gives 01, OWN1 gives 10, IDLE gives 00.
- A transfer is valid & ready in the same cycle. On each transfer: bcnt+1, wcountx+1.
- Release condition in OWNx: a transfer with bcnt==BURST-1, OR reqx_valid==0. A cycle with valid=1 and `f_full`=1 is a stall, not a release.
- On release: bcnt←0, last←x. Next state:
  - OWN(other) if the other producer's valid is 1.
  - Otherwise OWNx if reqx_valid is still 1 (burst-limit release with no competitor).
  - Otherwise IDLE.
- A release by burst limit and a new owner take effect on the same edge, so there is no idle bubble between owners.
- Producers must hold data stable while valid & ~ready. The block does not check this.
- `fifo_wr_data` is `16'h0000` when no write is enabled.

## Timing
- Request to first transfer from IDLE: 1 cycle. Valid seen in cycle N gives ready possible in cycle N+1.
- Sustained throughput while owned and not full: 1 word/cycle.
- Handover between producers under contention: 0 idle cycles.
- Word written into FIFO at the same edge it is accepted (zero-latency pass-through).
- Full boundary: when `f_full`=1, no ready and no write. Ownership and bcnt are held, and the transfer resumes the cycle `f_full` drops.
- Counter wrap: wcountx at 16'hFFFF plus one transfer gives 16'h0000.
- BURST=1: ownership alternates every word when both producers are valid.

## Test plan
- Reset then single producer. Apply rst for 2 cycles, then req0_valid=1 with data 0x1000..0x1009.
  - Required: ready high from the second cycle onward, 10 consecutive writes with `grant`=01.
  - Required: burst-limit releases re-grant producer 0 without a bubble; wcount0=10.
- Contention with BURST=4 and both producers valid continuously.
  - Required write order: 4 words from producer 0, then 4 from producer 1, then 4 from producer 0.
  - Required: `grant` switches with no cycle where `fifo_wr_en`=0.
- Full stall. Hold `f_full`=1 for 3 cycles mid-burst after 2 words.
  - Required: `fifo_wr_en`=0 and ready=0 for those 3 cycles, owner and bcnt unchanged.
  - Required: the remaining 2 words are written afterward, then release.
- Valid drop. Producer 1 owns and deasserts valid after 1 word while producer 0 is valid.
  - Required: the next edge grants OWN0, and last=1.
- Reset mid-burst. Assert rst during OWN1 with bcnt=2.
  - Required: no write in the rst cycle.
  - Required afterward: state IDLE, wcount0=wcount1=0, and a subsequent tie is granted to producer 0.
- Wrap. Preload via 65536+3 transfers from producer 0 (or force).
  - Required: wcount0=3 after the wrap, with no effect on wcount1.
